instruction_sequencer: RTL and testbench

Multi-cycle sequencer wrapping the processor's combinational control unit: steps each instruction through fetch, decode, execute, memory and writeback states. Converts the control unit's level outputs into single-cycle strobes for the PC, instruction register, register file, data RAM and I/O. Handles branch resolution, input/output handshakes with timeout, halt and single-step.

---
 rtl/sequencer_pkg.sv | 50 +++++
 rtl/instruction_sequencer_io_wait_timer.sv | 42 ++++
 rtl/instruction_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instruction_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// sequencer_pkg: state codes, opcodes and opcode-class decode
// shared by the instruction sequencer and its timer
package sequencer_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXECUTE   = 4'd3;
  localparam logic [3:0] S_MEMORY    = 4'd4;
  localparam logic [3:0] S_WRITEBACK = 4'd5;
  localparam logic [3:0] S_WAIT_IN   = 4'd6;
  localparam logic [3:0] S_WAIT_OUT  = 4'd7;
  localparam logic [3:0] S_HALT      = 4'd8;

  localparam logic [5:0] OP_HLT     = 6'b011100;
  localparam logic [5:0] OP_IN      = 6'b011101;
  localparam logic [5:0] OP_OUT     = 6'b100000;
  localparam logic [5:0] OP_PRE_OUT = 6'b011110;
  localparam logic [5:0] OP_LD      = 6'b011000;
  localparam logic [5:0] OP_ST      = 6'b011001;
  localparam logic [5:0] OP_LDR     = 6'b100001;
  localparam logic [5:0] OP_STR     = 6'b100010;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_IN,
    CLS_OUT,
    CLS_HLT
  } op_class_e;

  // Anything not listed (ALU, branch, jmp, ldi, nop, undefined)
  // takes the plain execute path.
  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e cls;
    unique case (op)
      OP_HLT:     cls = CLS_HLT;
      OP_IN:      cls = CLS_IN;
      OP_OUT:     cls = CLS_OUT;
      OP_PRE_OUT: cls = CLS_OUT;
      OP_LD:      cls = CLS_MEM;
      OP_ST:      cls = CLS_MEM;
      OP_LDR:     cls = CLS_MEM;
      OP_STR:     cls = CLS_MEM;
      default:    cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instruction_sequencer_io_wait_timer.sv
// io_wait_timer: counts cycles spent in an I/O wait state
// expired is high in the IO_TIMEOUT-th enabled cycle; 0 disables it
module io_wait_timer #(
  parameter int unsigned IO_TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW =
    (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((IO_TIMEOUT == 0) ? 0 : IO_TIMEOUT - 1);
  localparam logic ARMED = (IO_TIMEOUT != 0);

  logic [CW-1:0] count_q, count_d;

  // clear dominates; count only while waiting
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  // cycle counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = ARMED & enable & (count_q == LAST);

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle FSM around the control unit
// turns control levels into one-cycle PC/IR/RF/RAM/IO strobes
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned IO_TIMEOUT  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   stepMode,
  input  logic                   step,
  input  logic [5:0]             opcode,
  input  logic                   writeRegister,
  input  logic                   writeEnable,
  input  logic                   IO_RAMwrite,
  input  logic                   jump,
  input  logic                   bzero,
  input  logic                   bnegative,
  input  logic                   HLT,
  input  logic                   zeroFlag,
  input  logic                   negativeFlag,
  input  logic                   inputValid,
  input  logic                   outputAck,
  output logic                   irLoad,
  output logic                   pcEnable,
  output logic                   pcLoad,
  output logic                   regWriteStrobe,
  output logic                   memWriteStrobe,
  output logic                   ioWriteStrobe,
  output logic                   inputRequest,
  output logic                   halted,
  output logic                   ioTimeout,
  output logic [COUNT_WIDTH-1:0] instructionCount,
  output logic [3:0]             state
);

  logic [3:0]             state_q, state_d;
  op_class_e              cls_q, cls_d;
  logic                   first_q, first_d;
  logic                   supp_q, supp_d;
  logic                   tmo_q, tmo_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  op_class_e cls_dec;
  logic      in_wait;
  logic      expired;
  logic      take;
  logic      wb;

  // either the hlt opcode or the control unit's HLT level halts
  assign cls_dec = HLT ? CLS_HLT : op_class(opcode);
  assign in_wait = (state_q == S_WAIT_IN) |
                   (state_q == S_WAIT_OUT);
  assign take    = jump | (bzero & zeroFlag) |
                   (bnegative & negativeFlag);
  assign wb      = (state_q == S_WRITEBACK);

  io_wait_timer #(
    .IO_TIMEOUT(IO_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  // next-state, class latch, timeout/suppress flags, retire count
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    supp_d  = supp_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    first_d = (state_q == S_DECODE);
    case (state_q)
      S_IDLE: begin
        if (run && (!stepMode || step)) state_d = S_FETCH;
      end
      S_FETCH: begin
        supp_d  = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d = cls_dec;
        unique case (1'b1)
          cls_dec == CLS_HLT: state_d = S_HALT;
          cls_dec == CLS_IN:  state_d = S_WAIT_IN;
          cls_dec == CLS_OUT: state_d = S_WAIT_OUT;
          default:            state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        state_d = (cls_q == CLS_MEM) ? S_MEMORY
                                     : S_WRITEBACK;
      end
      S_MEMORY: begin
        state_d = S_WRITEBACK;
      end
      S_WAIT_IN: begin
        // a valid word arriving with the timeout still counts
        if (inputValid) begin
          state_d = S_WRITEBACK;
        end else if (expired) begin
          tmo_d   = 1'b1;
          supp_d  = 1'b1;
          state_d = S_WRITEBACK;
        end
      end
      S_WAIT_OUT: begin
        if (outputAck) begin
          state_d = S_WRITEBACK;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        count_d = count_q + COUNT_WIDTH'(1);
        state_d = (stepMode || !run) ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // sequencer state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_ALU;
      first_q <= 1'b0;
      supp_q  <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      first_q <= first_d;
      supp_q  <= supp_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  assign irLoad           = (state_q == S_FETCH);
  assign pcLoad           = wb & take;
  assign pcEnable         = wb & !take;
  assign regWriteStrobe   = wb & writeRegister & !supp_q;
  assign memWriteStrobe   = (state_q == S_MEMORY) & writeEnable;
  assign ioWriteStrobe    = (state_q == S_WAIT_OUT) & first_q &
                            IO_RAMwrite;
  assign inputRequest     = (state_q == S_WAIT_IN);
  assign halted           = (state_q == S_HALT);
  assign ioTimeout        = tmo_q;
  assign instructionCount = count_q;
  assign state            = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed table, random model check
// and hand sequences for run-drop, step, reset and halt
module tb_instruction_sequencer;

  localparam int unsigned CW  = 8;
  localparam int          TMO = 8;
  localparam int          NT  = 12;

  localparam logic [5:0] O_ADD  = 6'b000000;
  localparam logic [5:0] O_BZ   = 6'b010011;
  localparam logic [5:0] O_BN   = 6'b010100;
  localparam logic [5:0] O_JMP  = 6'b010101;
  localparam logic [5:0] O_HLT  = 6'b011100;
  localparam logic [5:0] O_IN   = 6'b011101;
  localparam logic [5:0] O_OUT  = 6'b100000;
  localparam logic [5:0] O_POUT = 6'b011110;
  localparam logic [5:0] O_LD   = 6'b011000;
  localparam logic [5:0] O_ST   = 6'b011001;
  localparam logic [5:0] O_LDR  = 6'b100001;
  localparam logic [5:0] O_STR  = 6'b100010;
  localparam logic [3:0] IDLE   = sequencer_pkg::S_IDLE;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0, stepMode = 1'b0, step = 1'b0;
  logic [5:0]    opcode = '0;
  logic          writeRegister = 1'b0, writeEnable = 1'b0;
  logic          IO_RAMwrite = 1'b0, jump = 1'b0;
  logic          bzero = 1'b0, bnegative = 1'b0, HLT = 1'b0;
  logic          zeroFlag = 1'b0, negativeFlag = 1'b0;
  logic          inputValid = 1'b0, outputAck = 1'b0;
  logic          irLoad, pcEnable, pcLoad;
  logic          regWriteStrobe, memWriteStrobe, ioWriteStrobe;
  logic          inputRequest, halted, ioTimeout;
  logic [CW-1:0] instructionCount;
  logic [3:0]    state;

  always #5 clock = ~clock;

  instruction_sequencer #(
    .COUNT_WIDTH(CW),
    .IO_TIMEOUT (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .stepMode        (stepMode),
    .step            (step),
    .opcode          (opcode),
    .writeRegister   (writeRegister),
    .writeEnable     (writeEnable),
    .IO_RAMwrite     (IO_RAMwrite),
    .jump            (jump),
    .bzero           (bzero),
    .bnegative       (bnegative),
    .HLT             (HLT),
    .zeroFlag        (zeroFlag),
    .negativeFlag    (negativeFlag),
    .inputValid      (inputValid),
    .outputAck       (outputAck),
    .irLoad          (irLoad),
    .pcEnable        (pcEnable),
    .pcLoad          (pcLoad),
    .regWriteStrobe  (regWriteStrobe),
    .memWriteStrobe  (memWriteStrobe),
    .ioWriteStrobe   (ioWriteStrobe),
    .inputRequest    (inputRequest),
    .halted          (halted),
    .ioTimeout       (ioTimeout),
    .instructionCount(instructionCount),
    .state           (state)
  );

  typedef struct {
    logic [5:0] op;
    logic wr, we, iorw, jmp, bz, bn, zf, nf;
    int   dly;
  } instr_t;

  typedef struct {
    instr_t t;
    int len, pcl, pce, rw, mw, iw, req;
    logic tmo;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] trace[$];
  logic [7:0] exp_q[$];
  int m_count;
  logic m_tmo;
  vec_t tbl[NT];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outv();
    return {irLoad, pcEnable, pcLoad, regWriteStrobe,
            memWriteStrobe, ioWriteStrobe, inputRequest,
            halted};
  endfunction

  function automatic instr_t mi(
      logic [5:0] op, logic wr, logic we, logic iorw,
      logic jmp, logic bz, logic bn, logic zf, logic nf,
      int dly);
    instr_t t;
    t.op = op; t.wr = wr; t.we = we; t.iorw = iorw;
    t.jmp = jmp; t.bz = bz; t.bn = bn;
    t.zf = zf; t.nf = nf; t.dly = dly;
    return t;
  endfunction

  function automatic vec_t mv(instr_t t, int len, int pcl,
      int pce, int rw, int mw, int iw, int req, logic tmo);
    vec_t v;
    v.t = t; v.len = len; v.pcl = pcl; v.pce = pce;
    v.rw = rw; v.mw = mw; v.iw = iw; v.req = req;
    v.tmo = tmo;
    return v;
  endfunction

  // drive one instruction from its FETCH cycle until next FETCH
  task automatic run_instr(input instr_t t);
    trace.delete();
    opcode = t.op; writeRegister = t.wr;
    writeEnable = t.we; IO_RAMwrite = t.iorw;
    jump = t.jmp; bzero = t.bz; bnegative = t.bn;
    zeroFlag = t.zf; negativeFlag = t.nf; HLT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      inputValid = (t.dly != 0) && (i == t.dly + 1);
      outputAck  = (t.dly != 0) && (i == t.dly + 1);
      #1;
      if (i > 0 && irLoad) break;
      trace.push_back(outv());
      @(posedge clock); #1;
    end
    inputValid = 1'b0;
    outputAck  = 1'b0;
  endtask

  // expected per-cycle outputs of one instruction from the rules
  task automatic model(input instr_t t);
    bit tk, is_in, is_out, is_mem, hit;
    int n;
    exp_q.delete();
    is_in  = (t.op == O_IN);
    is_out = (t.op == O_OUT) || (t.op == O_POUT);
    is_mem = t.op inside {O_LD, O_ST, O_LDR, O_STR};
    tk  = t.jmp | (t.bz & t.zf) | (t.bn & t.nf);
    hit = 1'b0;
    n   = 0;
    exp_q.push_back(8'b1000_0000);
    exp_q.push_back(8'b0000_0000);
    if (is_in || is_out) begin
      if (t.dly != 0 && t.dly <= TMO) n = t.dly;
      else begin n = TMO; hit = 1'b1; end
      for (int k = 0; k < n; k++)
        exp_q.push_back({5'b0, is_out && k == 0 && t.iorw,
                         is_in, 1'b0});
    end else begin
      exp_q.push_back(8'b0);
      if (is_mem) exp_q.push_back({4'b0, t.we, 3'b0});
    end
    exp_q.push_back({1'b0, !tk, tk,
                     t.wr && !(is_in && hit), 4'b0});
    if (hit) m_tmo = 1'b1;
    m_count = (m_count + 1) % (1 << CW);
  endtask

  function automatic instr_t rnd_instr();
    instr_t t;
    int cls;
    t = mi(6'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 0);
    cls = $urandom_range(0, 3);
    case (cls)
      0: begin
        while (t.op inside {O_HLT, O_IN, O_OUT, O_POUT,
                            O_LD, O_ST, O_LDR, O_STR})
          t.op = 6'($urandom);
      end
      1: begin
        case ($urandom_range(0, 3))
          0: t.op = O_LD;
          1: t.op = O_ST;
          2: t.op = O_LDR;
          default: t.op = O_STR;
        endcase
      end
      2: t.op = O_IN;
      default: t.op = $urandom_range(0, 1) ? O_OUT : O_POUT;
    endcase
    if (cls >= 2) t.dly = $urandom_range(0, TMO + 1);
    return t;
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pcl, pce, rw, mw, iw, req, n, bad, fetches;
    logic [CW-1:0] c0;

    tbl[0]  = mv(mi(O_ADD, 1,0,0, 0,0,0, 0,0, 0), 4,0,1,1,0,0,0,0);
    tbl[1]  = mv(mi(O_ST,  0,1,0, 0,0,0, 0,0, 0), 5,0,1,0,1,0,0,0);
    tbl[2]  = mv(mi(O_BZ,  0,0,0, 0,1,0, 1,0, 0), 4,1,0,0,0,0,0,0);
    tbl[3]  = mv(mi(O_BZ,  0,0,0, 0,1,0, 0,0, 0), 4,0,1,0,0,0,0,0);
    tbl[4]  = mv(mi(O_BN,  0,0,0, 0,0,1, 0,1, 0), 4,1,0,0,0,0,0,0);
    tbl[5]  = mv(mi(O_JMP, 0,0,0, 1,0,0, 0,0, 0), 4,1,0,0,0,0,0,0);
    tbl[6]  = mv(mi(O_IN,  1,0,0, 0,0,0, 0,0, 7),10,0,1,1,0,0,7,0);
    tbl[7]  = mv(mi(O_IN,  1,0,0, 0,0,0, 0,0, 8),11,0,1,1,0,0,8,0);
    tbl[8]  = mv(mi(O_OUT, 0,0,1, 0,0,0, 0,0, 1), 4,0,1,0,0,1,0,0);
    tbl[9]  = mv(mi(O_POUT,0,0,1, 0,0,0, 0,0, 3), 6,0,1,0,0,1,0,0);
    tbl[10] = mv(mi(O_LD,  1,0,0, 0,0,0, 0,0, 0), 5,0,1,1,0,0,0,0);
    tbl[11] = mv(mi(O_IN,  1,0,0, 0,0,0, 0,0, 0),11,0,1,0,0,0,8,1);

    // reset state
    #12;
    check("reset outputs", outv(), 0);
    check("reset state", state, IDLE);
    check("reset count", instructionCount, 0);
    check("reset ioTimeout", ioTimeout, 0);
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b1;
    @(posedge clock); #1;

    // directed table
    for (int i = 0; i < NT; i++) begin
      run_instr(tbl[i].t);
      pcl = 0; pce = 0; rw = 0; mw = 0; iw = 0; req = 0;
      foreach (trace[k]) begin
        pcl += trace[k][5]; pce += trace[k][6];
        rw  += trace[k][4]; mw  += trace[k][3];
        iw  += trace[k][2]; req += trace[k][1];
      end
      n = trace.size();
      check($sformatf("t%0d len", i), n, tbl[i].len);
      check($sformatf("t%0d irLoad first", i),
            trace[0][7], 1);
      check($sformatf("t%0d wb last", i),
            trace[n-1][6] | trace[n-1][5], 1);
      check($sformatf("t%0d pcLoad", i), pcl, tbl[i].pcl);
      check($sformatf("t%0d pcEnable", i), pce, tbl[i].pce);
      check($sformatf("t%0d regWrite", i), rw, tbl[i].rw);
      check($sformatf("t%0d memWrite", i), mw, tbl[i].mw);
      check($sformatf("t%0d ioWrite", i), iw, tbl[i].iw);
      check($sformatf("t%0d inputRequest", i), req, tbl[i].req);
      check($sformatf("t%0d ioTimeout", i),
            ioTimeout, tbl[i].tmo);
    end
    check("table count", instructionCount, NT);

    // random instructions against the model (wraps the counter)
    m_count = NT;
    m_tmo   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      instr_t t;
      t = rnd_instr();
      model(t);
      run_instr(t);
      check($sformatf("r%0d len op %b", i, t.op),
            trace.size(), exp_q.size());
      for (int k = 0; k < trace.size() && k < exp_q.size(); k++)
        check($sformatf("r%0d cyc%0d op %b", i, k, t.op),
              trace[k], exp_q[k]);
      check($sformatf("r%0d count", i), instructionCount,
            m_count);
      check($sformatf("r%0d ioTimeout", i), ioTimeout, m_tmo);
    end

    // run drops in FETCH: instruction still completes, then IDLE
    opcode = O_ADD; writeRegister = 1'b1; writeEnable = 1'b0;
    jump = 1'b0; bzero = 1'b0; bnegative = 1'b0;
    IO_RAMwrite = 1'b0;
    run = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    check("drop wb strobe", {regWriteStrobe, pcEnable}, 2'b11);
    @(posedge clock); #1;
    check("drop idle", state, IDLE);
    check("drop count", instructionCount, (m_count + 1) % 256);
    repeat (3) begin @(posedge clock); #1; end
    check("drop stays idle", {irLoad, state}, {1'b0, IDLE});

    // single-step: three pulses retire exactly three
    c0 = instructionCount;
    stepMode = 1'b1;
    run = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    check("step waits", {irLoad, state}, {1'b0, IDLE});
    fetches = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(posedge clock); #1;
      step = 1'b0;
      for (int c = 0; c < 6; c++) begin
        fetches += int'(irLoad);
        @(posedge clock); #1;
      end
      check($sformatf("step%0d idle", p), state, IDLE);
    end
    check("step fetches", fetches, 3);
    check("step retired", instructionCount, CW'(c0 + 3));

    // reset asserted while in MEMORY of a store
    stepMode = 1'b0;
    opcode = O_ST; writeRegister = 1'b0; writeEnable = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    check("mem strobe", memWriteStrobe, 1);
    reset = 1'b0;
    #1;
    check("rst mem state", state, IDLE);
    check("rst mem outputs", outv(), 0);
    check("rst mem count", instructionCount, 0);
    check("rst mem ioTimeout", ioTimeout, 0);

    // halt is absorbing and does not retire
    opcode = O_HLT; HLT = 1'b1; writeEnable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("hlt fetch", {irLoad, halted}, 2'b10);
    repeat (2) begin @(posedge clock); #1; end
    check("hlt halted", halted, 1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      run = 1'($urandom);
      inputValid = 1'($urandom);
      @(posedge clock); #1;
      if (!halted || instructionCount != 0 || irLoad) bad++;
    end
    check("hlt absorbing", bad, 0);
    reset = 1'b0;
    #1;
    check("hlt reset", {halted, state}, {1'b0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
